// File: rtl/emul_pkg.sv
// Shared definitions for the sequential shift-add multiplier feeding the
// accumulator: default operand widths, product width and FSM encoding.
package emul_pkg;

  localparam int unsigned WA_DEF = 16;
  localparam int unsigned WB_DEF = 15;
  localparam int unsigned PROD_W = 31;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/emul_seq_reg.sv
// Generic N-bit register with load enable and asynchronous active-high clear.
module emul_seq_reg #(
  parameter int unsigned N = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_q
);

  // Capture i_d when loaded, otherwise hold
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_q <= '0;
    end else if (i_load) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/emul_seq.sv
// Sequential unsigned multiplier: one multiplier bit per cycle, LSB first.
// start sampled in cycle 0 gives a one-cycle mul_valid in cycle WB+1.
// mul_out/mul_valid drive the accumulator's mul_in/enable directly.
module emul_seq
  import emul_pkg::*;
#(
  parameter int unsigned WA = WA_DEF,
  parameter int unsigned WB = WB_DEF
) (
  input  logic             clk,
  input  logic             rst_n,      // active-high despite the name
  input  logic             start,
  input  logic             clr,
  input  logic [WA-1:0]    mcand,
  input  logic [WB-1:0]    mplier,
  output logic             busy,
  output logic             mul_valid,
  output logic [WA+WB-1:0] mul_out
);

  localparam int unsigned PW = WA + WB;
  localparam int unsigned CW = (WB > 1) ? $clog2(WB) : 1;

  if (PW != PROD_W) begin : g_bad_width
    $error("emul_seq: WA+WB must equal PROD_W");
  end

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [PW-1:0]  r_mc;      // multiplicand, shifted left once per iteration
  logic [WB-1:0]  r_mp;      // multiplier, shifted right so bit 0 is current
  logic [PW-1:0]  r_pp;      // partial product
  logic           r_busy;
  logic           r_valid;

  logic [PW-1:0]  w_add;
  logic [PW-1:0]  w_sum;
  logic           w_load;

  // Current iteration's partial sum; on the last iteration it is the product
  always_comb begin
    w_add  = r_mp[0] ? r_mc : '0;
    w_sum  = r_pp + w_add;
    w_load = (r_state == RUN) && (r_cnt == '0) && !clr;
  end

  // Control FSM and datapath registers; clr aborts from any state
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_mc    <= '0;
      r_mp    <= '0;
      r_pp    <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else if (clr) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_valid <= 1'b0;
          if (start) begin
            r_mc    <= PW'(mcand);
            r_mp    <= mplier;
            r_pp    <= '0;
            r_cnt   <= CW'(WB - 1);
            r_state <= RUN;
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        RUN: begin
          r_pp <= w_sum;
          r_mc <= r_mc << 1;
          r_mp <= r_mp >> 1;
          if (r_cnt == '0) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  emul_seq_reg #(
    .N (PROD_W)
  ) u_out_reg (
    .i_clk  (clk),
    .i_rst  (rst_n),
    .i_load (w_load),
    .i_d    (w_sum),
    .o_q    (mul_out)
  );

  assign busy      = r_busy;
  assign mul_valid = r_valid;

endmodule

// File: tb/tb_emul_seq.sv
// Scoreboard bench for emul_seq: stimulus pushes expected product and cycle,
// a negedge monitor pops and checks on every mul_valid.
module tb_emul_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        clr;
  logic [15:0] mcand;
  logic [14:0] mplier;
  logic        busy;
  logic        mul_valid;
  logic [30:0] mul_out;

  typedef struct {
    logic [30:0] prod;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   total;
  int   bad;

  emul_seq #(
    .WA (16),
    .WB (15)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .clr       (clr),
    .mcand     (mcand),
    .mplier    (mplier),
    .busy      (busy),
    .mul_valid (mul_valid),
    .mul_out   (mul_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every mul_valid must match the oldest expected product and cycle
  always @(negedge clk) begin
    if (mul_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got mul_out 0x%0h expected no valid (cyc %0d)", mul_out, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("mul_out", 64'(mul_out), 64'(e.prod));
        check("valid_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Call just after a negedge (that cycle is cycle 0); returns at cycle 1
  task automatic issue(input logic [15:0] a, input logic [14:0] b, input bit expect_result);
    exp_t e;
    start  = 1'b1;
    mcand  = a;
    mplier = b;
    if (expect_result) begin
      e.prod = 31'(a) * 31'(b);
      e.cyc  = cyc + 16;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst_n  = 1'b1;
    start  = 1'b0;
    clr    = 1'b0;
    mcand  = '0;
    mplier = '0;

    // reset state
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(mul_valid), 64'd0);
    check("rst_mul_out", 64'(mul_out), 64'd0);
    @(negedge clk);

    // 3*5 issued on the first edge after reset release; busy in cycles 1-15
    rst_n = 1'b0;
    issue(16'h0003, 15'h0005, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      check("busy_window", 64'(busy), 64'(k <= 15));
      if (k < 16) @(negedge clk);
    end
    @(negedge clk);

    // max operands, then back-to-back start in the DONE cycle
    issue(16'hFFFF, 15'h7FFF, 1'b1);
    repeat (15) @(negedge clk);
    check("done_busy", 64'(busy), 64'd0);
    issue(16'h0002, 15'h0004, 1'b1);
    repeat (16) @(negedge clk);

    // start during RUN is ignored
    issue(16'h0007, 15'h0009, 1'b1);
    repeat (4) @(negedge clk);
    start  = 1'b1;
    mcand  = 16'd100;
    mplier = 15'd100;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_ignored_start", 64'(busy), 64'd1);
    repeat (12) @(negedge clk);
    check("hold_after_run_start", 64'(mul_out), 64'd63);

    // clr at cycle 8 of RUN aborts; mul_out kept
    issue(16'h0005, 15'h0006, 1'b0);
    repeat (7) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_busy", 64'(busy), 64'd0);
    repeat (20) @(negedge clk);
    check("clr_hold_mul_out", 64'(mul_out), 64'd63);

    // clr beats start
    clr    = 1'b1;
    start  = 1'b1;
    mcand  = 16'd1;
    mplier = 15'd1;
    @(negedge clk);
    clr   = 1'b0;
    start = 1'b0;
    check("clr_prio_busy", 64'(busy), 64'd0);
    repeat (20) @(negedge clk);
    check("clr_prio_mul_out", 64'(mul_out), 64'd63);

    // reset asserted mid-RUN between edges
    issue(16'h0009, 15'h0009, 1'b0);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_mul_out", 64'(mul_out), 64'd0);
    check("midrst_valid", 64'(mul_valid), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_mul_out", 64'(mul_out), 64'd0);
    issue(16'h000B, 15'h000D, 1'b1);
    repeat (18) @(negedge clk);

    check("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
